// File: rtl/player_motion_multi_pkg.sv
// Shared state encodings and default sprite codes for the multi-player motion updater.
package player_motion_multi_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DUCK = 3'd1;
  localparam logic [2:0] ST_RISE = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_FALL = 3'd4;

  localparam int DEF_RUN_TYPE0  = 1;
  localparam int DEF_DUCK_TYPE0 = 3;
  localparam int DEF_JUMP_TYPE  = 5;
  localparam int DEF_TITLE_TYPE = 0;

  function automatic logic is_airborne(input logic [2:0] st);
    return (st == ST_RISE) || (st == ST_HOLD) || (st == ST_FALL);
  endfunction

endpackage

// File: rtl/player_motion_fsm.sv
// One player channel: jump/duck state machine, explicit y trajectory, run animation
// and jump-button edge detector.
module player_motion_fsm
  import player_motion_multi_pkg::*;
#(
  parameter int YW          = 10,
  parameter int TW          = 6,
  parameter int GROUND_Y    = 200,
  parameter int FLOAT_MAX   = 80,
  parameter int RISE_TICKS  = 20,
  parameter int HOLD_TICKS  = 10,
  parameter int FALL_TICKS  = 20,
  parameter int ANIM_PERIOD = 4,
  parameter int NFRAMES     = 2,
  parameter int RUN_TYPE0   = DEF_RUN_TYPE0,
  parameter int DUCK_TYPE0  = DEF_DUCK_TYPE0,
  parameter int JUMP_TYPE   = DEF_JUMP_TYPE,
  parameter int TITLE_TYPE  = DEF_TITLE_TYPE
) (
  input  logic          clk3,
  input  logic          reset,
  input  logic          pause,
  input  logic          start,
  input  logic          jump_n,
  input  logic          duck_n,
  output logic [YW-1:0] y,
  output logic [TW-1:0] ptype,
  output logic          airborne,
  output logic          landed
);

  localparam int RSTEP = FLOAT_MAX / RISE_TICKS;
  localparam int FSTEP = FLOAT_MAX / FALL_TICKS;
  localparam int HW    = $clog2(HOLD_TICKS + 1);
  localparam int PW    = $clog2(ANIM_PERIOD + 1);
  localparam int FW    = $clog2(NFRAMES + 1);

  localparam logic [YW:0]   GROUND_W = (YW+1)'(GROUND_Y);
  localparam logic [YW:0]   APEX_W   = (YW+1)'(GROUND_Y - FLOAT_MAX);
  localparam logic [YW-1:0] GROUND_V = YW'(GROUND_Y);
  localparam logic [YW-1:0] APEX_V   = YW'(GROUND_Y - FLOAT_MAX);

  // Saturating moves: y is kept inside [apex, ground] whatever the step size.
  function automatic logic [YW-1:0] step_up(input logic [YW-1:0] cur, input int step);
    logic [YW:0] wide;
    wide = {1'b0, cur};
    if (wide >= APEX_W + (YW+1)'(step)) return YW'(wide - (YW+1)'(step));
    return APEX_V;
  endfunction

  function automatic logic [YW-1:0] step_down(input logic [YW-1:0] cur, input int step);
    logic [YW:0] sum;
    sum = {1'b0, cur} + (YW+1)'(step);
    if (sum >= GROUND_W) return GROUND_V;
    return YW'(sum);
  endfunction

  logic [2:0]    state_q, state_d;
  logic [YW-1:0] y_q, y_d;
  logic [TW-1:0] type_q, type_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [PW-1:0] per_q, per_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          landed_q, landed_d;
  logic          jump_prev_q, jump_prev_d;

  logic press, release_ev, fast_drop;
  logic [YW-1:0] y_rise, y_fall;

  assign press      = !jump_n && jump_prev_q;
  assign release_ev = jump_n && !jump_prev_q;
  assign fast_drop  = !duck_n;
  assign y_rise     = step_up(y_q, RSTEP);
  assign y_fall     = step_down(y_q, fast_drop ? 2 * FSTEP : FSTEP);
  assign jump_prev_d = jump_n;

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    type_d   = type_q;
    hold_d   = hold_q;
    per_d    = per_q;
    frame_d  = frame_q;
    landed_d = 1'b0;
    if (!start) begin
      state_d = ST_IDLE;
      y_d     = GROUND_V;
      type_d  = TW'(TITLE_TYPE);
      hold_d  = '0;
      per_d   = '0;
      frame_d = '0;
    end else if (!pause) begin
      if (per_q == PW'(ANIM_PERIOD - 1)) begin
        per_d   = '0;
        frame_d = (frame_q == FW'(NFRAMES - 1)) ? '0 : frame_q + FW'(1);
      end else begin
        per_d = per_q + PW'(1);
      end
      case (state_q)
        ST_IDLE, ST_DUCK: begin
          if (press) begin
            state_d = ST_RISE;
            y_d     = YW'(GROUND_Y - RSTEP);
          end else if (state_q == ST_IDLE && !duck_n) begin
            state_d = ST_DUCK;
          end else if (state_q == ST_DUCK && duck_n) begin
            state_d = ST_IDLE;
          end
        end
        ST_RISE: begin
          if (release_ev || fast_drop) begin
            state_d = ST_FALL;
            y_d     = step_down(y_q, FSTEP);
          end else begin
            y_d = y_rise;
            if (y_rise == APEX_V) begin
              state_d = ST_HOLD;
              hold_d  = '0;
            end
          end
        end
        ST_HOLD: begin
          hold_d = hold_q + HW'(1);
          if (release_ev || fast_drop || hold_q == HW'(HOLD_TICKS - 1)) state_d = ST_FALL;
        end
        ST_FALL: begin
          y_d = y_fall;
          if (y_fall == GROUND_V) begin
            state_d  = ST_IDLE;
            landed_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          y_d     = GROUND_V;
        end
      endcase
      // Sprite follows the state being entered; frame is the one shown this tick.
      if (state_d == ST_IDLE)      type_d = TW'(RUN_TYPE0) + TW'(frame_q);
      else if (state_d == ST_DUCK) type_d = TW'(DUCK_TYPE0) + TW'(frame_q);
      else                         type_d = TW'(JUMP_TYPE);
    end
  end

  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      y_q      <= GROUND_V;
      type_q   <= TW'(TITLE_TYPE);
      hold_q   <= '0;
      per_q    <= '0;
      frame_q  <= '0;
      landed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      type_q   <= type_d;
      hold_q   <= hold_d;
      per_q    <= per_d;
      frame_q  <= frame_d;
      landed_q <= landed_d;
    end
  end

  // Unreset so it tracks the button while reset is held; a held button never fires on exit.
  always_ff @(posedge clk3) begin
    jump_prev_q <= jump_prev_d;
  end

  assign y        = y_q;
  assign ptype    = type_q;
  assign landed   = landed_q;
  assign airborne = is_airborne(state_q);

endmodule

// File: rtl/player_motion_multi.sv
// N independent player motion channels with packed outputs for the object renderer.
module player_motion_multi
  import player_motion_multi_pkg::*;
#(
  parameter int NPLAYER     = 2,
  parameter int YW          = 10,
  parameter int TW          = 6,
  parameter int GROUND_Y    = 200,
  parameter int FLOAT_MAX   = 80,
  parameter int RISE_TICKS  = 20,
  parameter int HOLD_TICKS  = 10,
  parameter int FALL_TICKS  = 20,
  parameter int ANIM_PERIOD = 4,
  parameter int NFRAMES     = 2,
  parameter int RUN_TYPE0   = DEF_RUN_TYPE0,
  parameter int DUCK_TYPE0  = DEF_DUCK_TYPE0,
  parameter int JUMP_TYPE   = DEF_JUMP_TYPE,
  parameter int TITLE_TYPE  = DEF_TITLE_TYPE
) (
  input  logic                  clk3,
  input  logic                  reset,
  input  logic                  pause,
  input  logic                  start,
  input  logic [NPLAYER-1:0]    jump_n,
  input  logic [NPLAYER-1:0]    duck_n,
  output logic [NPLAYER*YW-1:0] player_y,
  output logic [NPLAYER*TW-1:0] player_type,
  output logic [NPLAYER-1:0]    airborne,
  output logic [NPLAYER-1:0]    landed
);

  for (genvar gi = 0; gi < NPLAYER; gi++) begin : g_player
    player_motion_fsm #(
      .YW(YW), .TW(TW), .GROUND_Y(GROUND_Y), .FLOAT_MAX(FLOAT_MAX),
      .RISE_TICKS(RISE_TICKS), .HOLD_TICKS(HOLD_TICKS), .FALL_TICKS(FALL_TICKS),
      .ANIM_PERIOD(ANIM_PERIOD), .NFRAMES(NFRAMES), .RUN_TYPE0(RUN_TYPE0),
      .DUCK_TYPE0(DUCK_TYPE0), .JUMP_TYPE(JUMP_TYPE), .TITLE_TYPE(TITLE_TYPE)
    ) u_fsm (
      .clk3    (clk3),
      .reset   (reset),
      .pause   (pause),
      .start   (start),
      .jump_n  (jump_n[gi]),
      .duck_n  (duck_n[gi]),
      .y       (player_y[gi*YW +: YW]),
      .ptype   (player_type[gi*TW +: TW]),
      .airborne(airborne[gi]),
      .landed  (landed[gi])
    );
  end

endmodule

// File: tb/tb_player_motion_multi.sv
// Randomised and directed bench for player_motion_multi against a height-based jump model.
module tb_player_motion_multi;

  localparam int NP = 2;

  logic          clk3 = 1'b0;
  logic          reset;
  logic          pause;
  logic          start;
  logic [NP-1:0] jump_n;
  logic [NP-1:0] duck_n;
  logic [NP*10-1:0] player_y;
  logic [NP*6-1:0]  player_type;
  logic [NP-1:0] airborne;
  logic [NP-1:0] landed;

  int checks = 0;
  int errors = 0;

  player_motion_multi dut (
    .clk3(clk3), .reset(reset), .pause(pause), .start(start),
    .jump_n(jump_n), .duck_n(duck_n), .player_y(player_y),
    .player_type(player_type), .airborne(airborne), .landed(landed)
  );

  always #5 clk3 = ~clk3;

  // Model: height above ground (0..80), mode 0=ground 1=up 2=apex 3=down.
  int h[NP], mode[NP], at[NP], ticks[NP], etype[NP];
  bit ducking[NP], prevj[NP], lnd[NP];

  function automatic void model_reset();
    for (int i = 0; i < NP; i++) begin
      h[i] = 0; mode[i] = 0; at[i] = 0; ticks[i] = 0; etype[i] = 0;
      ducking[i] = 0; lnd[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    bit press, rel, dk;
    int fr, st;
    if (!reset) model_reset();
    else begin
      for (int i = 0; i < NP; i++) begin
        press = !jump_n[i] && prevj[i];
        rel   = jump_n[i] && !prevj[i];
        dk    = !duck_n[i];
        lnd[i] = 0;
        if (!start) begin
          mode[i] = 0; h[i] = 0; ticks[i] = 0; ducking[i] = 0; etype[i] = 0;
        end else if (!pause) begin
          fr = (ticks[i] / 4) % 2;
          ticks[i]++;
          case (mode[i])
            0: begin
              if (press) begin mode[i] = 1; h[i] = 4; ducking[i] = 0; end
              else ducking[i] = dk;
            end
            1: begin
              if (rel || dk) begin mode[i] = 3; h[i] = h[i] - 4; end
              else begin
                h[i] = h[i] + 4;
                if (h[i] >= 80) begin h[i] = 80; mode[i] = 2; at[i] = 0; end
              end
            end
            2: begin
              if (rel || dk || at[i] == 9) mode[i] = 3;
              else at[i]++;
            end
            default: begin
              st = dk ? 8 : 4;
              h[i] = (h[i] > st) ? h[i] - st : 0;
              if (h[i] == 0) begin mode[i] = 0; ducking[i] = 0; lnd[i] = 1; end
            end
          endcase
          etype[i] = (mode[i] == 0) ? ((ducking[i] ? 3 : 1) + fr) : 5;
        end
      end
    end
    for (int i = 0; i < NP; i++) prevj[i] = jump_n[i];
  endfunction

  function automatic logic [NP*10-1:0] exp_y();
    logic [NP*10-1:0] v;
    for (int i = 0; i < NP; i++) v[i*10 +: 10] = 10'(200 - h[i]);
    return v;
  endfunction

  function automatic logic [NP*6-1:0] exp_t();
    logic [NP*6-1:0] v;
    for (int i = 0; i < NP; i++) v[i*6 +: 6] = 6'(etype[i]);
    return v;
  endfunction

  function automatic logic [2*NP-1:0] exp_al();
    logic [2*NP-1:0] v;
    for (int i = 0; i < NP; i++) begin
      v[NP+i] = (mode[i] != 0);
      v[i]    = lnd[i];
    end
    return v;
  endfunction

  task automatic edge_step();
    @(posedge clk3);
    model_edge();
    #1;
  endtask

  task automatic settle(input int n);
    jump_n = '1; duck_n = '1; pause = 0; start = 1;
    for (int k = 0; k < n; k++) edge_step();
  endtask

  task automatic test_reset();
    reset = 0; pause = 0; start = 1; jump_n = '1; duck_n = '1;
    model_reset();
    for (int k = 0; k < 3; k++) edge_step();
    checks++;
    if ({player_y, player_type, airborne, landed} !== {20'({10'd200, 10'd200}), 12'd0, 2'b00, 2'b00}) begin
      errors++;
      $display("FAIL reset_values got %h want %h", {player_y, player_type, airborne, landed},
               {20'({10'd200, 10'd200}), 12'd0, 4'b0000});
    end
    reset = 1;
  endtask

  task automatic test_full_jump();
    jump_n[0] = 0;
    for (int k = 0; k < 52; k++) begin
      edge_step();
      checks++;
      if ({player_y, player_type, airborne, landed} !== {exp_y(), exp_t(), exp_al()}) begin
        errors++;
        $display("FAIL full_jump e%0d got %h want %h", k, {player_y, player_type, airborne, landed},
                 {exp_y(), exp_t(), exp_al()});
      end
      if (k == 19 || k == 29) begin
        checks++;
        if (player_y[9:0] !== 10'd120) begin
          errors++; $display("FAIL full_jump_apex e%0d y0=%0d want 120", k, player_y[9:0]);
        end
      end
      if (k == 49) begin
        checks++;
        if (landed !== 2'b01 || player_y[9:0] !== 10'd200) begin
          errors++; $display("FAIL full_jump_land landed=%b y0=%0d want 01/200", landed, player_y[9:0]);
        end
      end
    end
    settle(2);
  endtask

  task automatic test_short_hop();
    bit seen_apex;
    seen_apex = 0;
    jump_n[0] = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 9) jump_n[0] = 1;
      edge_step();
      if (player_y[9:0] == 10'd120) seen_apex = 1;
      checks++;
      if ({player_y, player_type, airborne, landed} !== {exp_y(), exp_t(), exp_al()}) begin
        errors++;
        $display("FAIL short_hop e%0d got %h want %h", k, {player_y, player_type, airborne, landed},
                 {exp_y(), exp_t(), exp_al()});
      end
      if (k == 17) begin
        checks++;
        if (landed[0] !== 1'b1) begin
          errors++; $display("FAIL short_hop_land landed0=%b want 1", landed[0]);
        end
      end
    end
    checks++;
    if (seen_apex) begin errors++; $display("FAIL short_hop_apex reached y=120 want never"); end
    settle(2);
  endtask

  task automatic test_fast_drop();
    int pulses;
    pulses = 0;
    jump_n[0] = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 24) duck_n[0] = 0;
      edge_step();
      pulses += landed[0];
      checks++;
      if ({player_y, player_type, airborne, landed} !== {exp_y(), exp_t(), exp_al()}) begin
        errors++;
        $display("FAIL fast_drop e%0d got %h want %h", k, {player_y, player_type, airborne, landed},
                 {exp_y(), exp_t(), exp_al()});
      end
      if (k == 25) begin
        checks++;
        if (player_y[9:0] !== 10'd128) begin
          errors++; $display("FAIL fast_drop_step y0=%0d want 128", player_y[9:0]);
        end
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL fast_drop_pulses got %0d want 1", pulses); end
    settle(2);
  endtask

  task automatic test_pause();
    pause = 1;
    edge_step();
    jump_n[0] = 0;
    edge_step(); edge_step();
    pause = 0;
    for (int k = 0; k < 5; k++) begin
      edge_step();
      checks++;
      if (airborne[0] !== 1'b0 || {player_y, player_type, airborne, landed} !== {exp_y(), exp_t(), exp_al()}) begin
        errors++; $display("FAIL paused_press e%0d airborne0=%b want 0", k, airborne[0]);
      end
    end
    jump_n[0] = 1;
    edge_step();
    jump_n[0] = 0;
    for (int k = 0; k < 15; k++) edge_step();
    pause = 1;
    for (int k = 0; k < 3; k++) begin
      edge_step();
      checks++;
      if (player_y[9:0] !== 10'd140) begin
        errors++; $display("FAIL pause_freeze e%0d y0=%0d want 140", k, player_y[9:0]);
      end
    end
    pause = 0;
    edge_step();
    checks++;
    if (player_y[9:0] !== 10'd136) begin
      errors++; $display("FAIL pause_resume y0=%0d want 136", player_y[9:0]);
    end
    for (int k = 0; k < 40; k++) begin
      edge_step();
      checks++;
      if ({player_y, player_type, airborne, landed} !== {exp_y(), exp_t(), exp_al()}) begin
        errors++;
        $display("FAIL pause_finish e%0d got %h want %h", k, {player_y, player_type, airborne, landed},
                 {exp_y(), exp_t(), exp_al()});
      end
    end
    settle(2);
  endtask

  task automatic test_duck_anim_title();
    int tbl[10] = '{3, 3, 3, 3, 4, 4, 4, 4, 3, 3};
    start = 0;
    edge_step();
    start = 1; duck_n[0] = 0;
    for (int k = 0; k < 10; k++) begin
      edge_step();
      checks++;
      if (player_type[5:0] !== 6'(tbl[k]) || player_type !== exp_t()) begin
        errors++;
        $display("FAIL duck_anim e%0d type=%h want %0d model %h", k, player_type, tbl[k], exp_t());
      end
    end
    start = 0;
    edge_step();
    checks++;
    if (player_type !== 12'd0 || player_y !== 20'({10'd200, 10'd200})) begin
      errors++; $display("FAIL title type=%h y=%h want 0/200,200", player_type, player_y);
    end
    settle(2);
  endtask

  task automatic test_both_players();
    int p0, p1;
    p0 = 0; p1 = 0;
    jump_n = 2'b00;
    for (int k = 0; k < 56; k++) begin
      if (k == 5) jump_n[1] = 1;
      edge_step();
      p0 += landed[0]; p1 += landed[1];
      checks++;
      if ({player_y, player_type, airborne, landed} !== {exp_y(), exp_t(), exp_al()}) begin
        errors++;
        $display("FAIL both e%0d got %h want %h", k, {player_y, player_type, airborne, landed},
                 {exp_y(), exp_t(), exp_al()});
      end
      if (k == 49) begin
        checks++;
        if (landed[0] !== 1'b1) begin errors++; $display("FAIL both_p0_land landed0=%b want 1", landed[0]); end
      end
    end
    checks++;
    if (p0 != 1 || p1 != 1) begin errors++; $display("FAIL both_pulses got %0d,%0d want 1,1", p0, p1); end
    settle(2);
  endtask

  task automatic test_random();
    for (int k = 0; k < 900; k++) begin
      for (int i = 0; i < NP; i++) begin
        if ($urandom_range(7) == 0) jump_n[i] = ~jump_n[i];
        if ($urandom_range(11) == 0) duck_n[i] = ~duck_n[i];
      end
      pause = ($urandom_range(19) == 0);
      start = ($urandom_range(79) != 0);
      edge_step();
      checks++;
      if ({player_y, player_type, airborne, landed} !== {exp_y(), exp_t(), exp_al()}) begin
        errors++;
        $display("FAIL random e%0d got %h want %h", k, {player_y, player_type, airborne, landed},
                 {exp_y(), exp_t(), exp_al()});
      end
    end
    settle(2);
  endtask

  task automatic test_async_reset();
    jump_n[1] = 0;
    for (int k = 0; k < 10; k++) edge_step();
    #2;
    reset = 0;
    #1;
    model_reset();
    checks++;
    if (player_y !== 20'({10'd200, 10'd200}) || airborne !== 2'b00) begin
      errors++; $display("FAIL async_reset y=%h air=%b want 200,200/00", player_y, airborne);
    end
    edge_step();
    reset = 1;
    for (int k = 0; k < 4; k++) begin
      edge_step();
      checks++;
      if (airborne !== 2'b00 || {player_y, player_type, airborne, landed} !== {exp_y(), exp_t(), exp_al()}) begin
        errors++; $display("FAIL held_after_reset e%0d airborne=%b want 00", k, airborne);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_jump();
    test_short_hop();
    test_fast_drop();
    test_pause();
    test_duck_anim_title();
    test_both_players();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
